instr_encoder: RTL and testbench

//  Encoder side of the CPU control decode path: converts field-level instruction requests

---
 rtl/cpu_types_pkg.sv | 56 +++++
 rtl/instr_pack.sv | 54 +++++
 rtl/instr_encoder.sv | 140 ++++++++++++++
 tb/tb_instr_encoder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: encoder request ops, MIPS opcodes/functs,
// fixed instruction words and the encoder FSM state type.
package cpu_types_pkg;

    // Field-level request kinds understood by the instruction encoder
    typedef enum logic [2:0] {
        ENC_R    = 3'd0,
        ENC_I    = 3'd1,
        ENC_J    = 3'd2,
        ENC_LI   = 3'd3,
        ENC_NOP  = 3'd4,
        ENC_HALT = 3'd5
    } enc_op_t;

    // Primary opcode field (instruction bits 31:26)
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_ORI   = 6'h0D,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_t;

    // R-type function field (instruction bits 5:0)
    typedef enum logic [5:0] {
        F_SLL = 6'h00,
        F_SRL = 6'h02,
        F_JR  = 6'h08,
        F_ADD = 6'h20,
        F_SUB = 6'h22,
        F_AND = 6'h24,
        F_OR  = 6'h25,
        F_SLT = 6'h2A
    } funct_t;

    // Encoder control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LI_LO  = 2'd1,
        ST_HALT_W = 2'd2,
        ST_DONE   = 2'd3
    } enc_state_t;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    // Op codes 6 and 7 have no encoding
    function automatic logic op_is_defined(input logic [2:0] op);
        return (op <= ENC_HALT);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Pure combinational packer: turns one field-level request into the MIPS
// word(s) it expands to. LI may need a second word, which is produced here
// up front so the encoder can park it while the first word drains.
module instr_pack
    import cpu_types_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [31:0] imm,
    output logic [31:0] first_word,
    output logic [31:0] second_word,
    output logic        two_words,
    output logic        illegal
);

    logic k_hi_zero;
    logic k_lo_zero;

    assign k_hi_zero = (imm[31:16] == 16'h0000);
    assign k_lo_zero = (imm[15:0]  == 16'h0000);

    // Field packing per request kind; LI picks ORI-only, LUI-only or LUI+ORI
    always_comb begin
        first_word  = NOP_WORD;
        second_word = NOP_WORD;
        two_words   = 1'b0;
        illegal     = !op_is_defined(op);
        case (op)
            ENC_R:    first_word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            ENC_I:    first_word = {opcode, rs, rt, imm[15:0]};
            ENC_J:    first_word = {opcode, imm[25:0]};
            ENC_NOP:  first_word = NOP_WORD;
            ENC_HALT: first_word = HALT_WORD;
            ENC_LI: begin
                if (rt == 5'd0) begin
                    illegal = 1'b1;
                end else if (k_hi_zero) begin
                    first_word = {OP_ORI, 5'd0, rt, imm[15:0]};
                end else begin
                    first_word  = {OP_LUI, 5'd0, rt, imm[31:16]};
                    second_word = {OP_ORI, rt, rt, imm[15:0]};
                    two_words   = !k_lo_zero;
                end
            end
            default: first_word = NOP_WORD;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts field-level requests, emits one 32-bit MIPS
// word per output handshake with its byte address, expands LI into LUI/ORI
// and stops for good once the HALT word has been taken.
module instr_encoder
    import cpu_types_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [5:0]        req_opcode,
    input  logic [5:0]        req_funct,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic [15:0]       out_count,
    output logic              err,
    output logic              done
);

    enc_state_t  state_q;
    enc_state_t  state_d;
    logic [31:0] pending_word;

    logic [31:0] pack_first;
    logic [31:0] pack_second;
    logic        pack_two;
    logic        pack_illegal;

    logic        stage_free;
    logic        out_fire;
    logic        req_fire;
    logic        load;
    logic [31:0] load_word;
    logic        err_d;

    instr_pack u_pack (
        .op          (req_op),
        .opcode      (req_opcode),
        .funct       (req_funct),
        .rs          (req_rs),
        .rt          (req_rt),
        .rd          (req_rd),
        .shamt       (req_shamt),
        .imm         (req_imm),
        .first_word  (pack_first),
        .second_word (pack_second),
        .two_words   (pack_two),
        .illegal     (pack_illegal)
    );

    assign stage_free = !out_valid || out_ready;
    assign out_fire   = out_valid && out_ready;
    assign req_fire   = req_valid && req_ready;
    assign done       = (state_q == ST_DONE);

    // Next state, handshake readiness and what (if anything) loads the output stage
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        load      = 1'b0;
        load_word = pack_first;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = stage_free;
                if (req_fire) begin
                    if (pack_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        load = 1'b1;
                        if (pack_two) begin
                            state_d = ST_LI_LO;
                        end else if (req_op == ENC_HALT) begin
                            state_d = ST_HALT_W;
                        end
                    end
                end
            end
            ST_LI_LO: begin
                if (stage_free) begin
                    load      = 1'b1;
                    load_word = pending_word;
                    state_d   = ST_IDLE;
                end
            end
            ST_HALT_W: begin
                if (out_fire) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, output stage, second-LI-word holding register, counters and err pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            out_valid    <= 1'b0;
            out_word     <= 32'h0;
            out_addr     <= BASE_ADDR;
            out_count    <= 16'h0;
            err          <= 1'b0;
            pending_word <= 32'h0;
        end else begin
            state_q <= state_d;
            err     <= err_d;
            if (req_fire) begin
                pending_word <= pack_second;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_word  <= load_word;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
            if (out_fire) begin
                out_addr <= out_addr + ADDR_W'(4);
                if (out_count != 16'hFFFF) begin
                    out_count <= out_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed words, addresses and flags,
// plus a 4-bit-address instance to exercise address wrap at full throughput.
module tb_instr_encoder;
    import cpu_types_pkg::*;

    localparam logic [15:0] BASE = 16'h0040;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [5:0]  req_opcode;
    logic [5:0]  req_funct;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [4:0]  req_shamt;
    logic [31:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [15:0] out_addr;
    logic [15:0] out_count;
    logic        err;
    logic        done;

    logic        s_req_valid;
    logic        s_req_ready;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [31:0] s_out_word;
    logic [3:0]  s_out_addr;
    logic [15:0] s_out_count;
    logic        s_err;
    logic        s_done;

    int checks;
    int errors;

    instr_encoder #(.ADDR_W(16), .BASE_ADDR(BASE)) u_dut (
        .CLK        (clk),
        .RST        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_opcode (req_opcode),
        .req_funct  (req_funct),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .req_rd     (req_rd),
        .req_shamt  (req_shamt),
        .req_imm    (req_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_addr   (out_addr),
        .out_count  (out_count),
        .err        (err),
        .done       (done)
    );

    instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'h0)) u_small (
        .CLK        (clk),
        .RST        (rst),
        .req_valid  (s_req_valid),
        .req_ready  (s_req_ready),
        .req_op     (ENC_NOP),
        .req_opcode (6'h00),
        .req_funct  (6'h00),
        .req_rs     (5'd0),
        .req_rt     (5'd0),
        .req_rd     (5'd0),
        .req_shamt  (5'd0),
        .req_imm    (32'h0),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_word   (s_out_word),
        .out_addr   (s_out_addr),
        .out_count  (s_out_count),
        .err        (s_err),
        .done       (s_done)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input logic [5:0] opcode, input logic [5:0] funct,
                                  input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [4:0] shamt, input logic [31:0] imm);
        req_op     = op;
        req_opcode = opcode;
        req_funct  = funct;
        req_rs     = rs;
        req_rt     = rt;
        req_rd     = rd;
        req_shamt  = shamt;
        req_imm    = imm;
        req_valid  = 1'b1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_op      = 3'd0;
        req_opcode  = 6'h0;
        req_funct   = 6'h0;
        req_rs      = 5'd0;
        req_rt      = 5'd0;
        req_rd      = 5'd0;
        req_shamt   = 5'd0;
        req_imm     = 32'h0;
        out_ready   = 1'b1;
        s_req_valid = 1'b0;
        s_out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        $display("[TB] reset state");
        check_output("rst_valid", 32'(out_valid), 32'h0);
        check_output("rst_word", out_word, 32'h0);
        check_output("rst_addr", 32'(out_addr), 32'h0040);
        check_output("rst_count", 32'(out_count), 32'h0);
        check_output("rst_err", 32'(err), 32'h0);
        check_output("rst_done", 32'(done), 32'h0);
        check_output("rst_ready", 32'(req_ready), 32'h1);

        $display("[TB] R-type ADD");
        apply_stimulus(ENC_R, 6'h00, F_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
        step();
        req_valid = 1'b0;
        check_output("add_valid", 32'(out_valid), 32'h1);
        check_output("add_word", out_word, 32'h0022_1820);
        check_output("add_addr", 32'(out_addr), 32'h0040);
        step();
        check_output("add_drained", 32'(out_valid), 32'h0);
        check_output("add_addr_inc", 32'(out_addr), 32'h0044);
        check_output("add_count", 32'(out_count), 32'h1);

        $display("[TB] LI two words");
        apply_stimulus(ENC_LI, 6'h00, 6'h00, 5'd0, 5'd4, 5'd0, 5'd0, 32'h1234_5678);
        step();
        req_valid = 1'b0;
        check_output("li2_lui", out_word, 32'h3C04_1234);
        check_output("li2_lui_addr", 32'(out_addr), 32'h0044);
        check_output("li2_ready_lo", 32'(req_ready), 32'h0);
        step();
        check_output("li2_ori", out_word, 32'h3484_5678);
        check_output("li2_ori_valid", 32'(out_valid), 32'h1);
        check_output("li2_ori_addr", 32'(out_addr), 32'h0048);
        step();
        check_output("li2_count", 32'(out_count), 32'h3);
        check_output("li2_idle_ready", 32'(req_ready), 32'h1);

        $display("[TB] LI single ORI / single LUI");
        apply_stimulus(ENC_LI, 6'h00, 6'h00, 5'd0, 5'd5, 5'd0, 5'd0, 32'h0000_BEEF);
        step();
        req_valid = 1'b0;
        check_output("li_ori_word", out_word, 32'h3405_BEEF);
        check_output("li_ori_ready", 32'(req_ready), 32'h1);
        apply_stimulus(ENC_LI, 6'h00, 6'h00, 5'd0, 5'd5, 5'd0, 5'd0, 32'hBEEF_0000);
        step();
        req_valid = 1'b0;
        check_output("li_lui_word", out_word, 32'h3C05_BEEF);
        check_output("li_lui_addr", 32'(out_addr), 32'h0050);
        step();
        check_output("li_single_count", 32'(out_count), 32'h5);
        check_output("li_single_valid", 32'(out_valid), 32'h0);

        $display("[TB] I-type ADDI");
        apply_stimulus(ENC_I, OP_ADDI, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 32'h0000_FFFC);
        step();
        req_valid = 1'b0;
        check_output("addi_word", out_word, 32'h2022_FFFC);
        step();
        check_output("addi_count", 32'(out_count), 32'h6);

        $display("[TB] illegal requests");
        apply_stimulus(ENC_LI, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h1234_5678);
        step();
        req_valid = 1'b0;
        check_output("li_rt0_err", 32'(err), 32'h1);
        check_output("li_rt0_valid", 32'(out_valid), 32'h0);
        step();
        check_output("li_rt0_err_pulse", 32'(err), 32'h0);
        check_output("li_rt0_count", 32'(out_count), 32'h6);
        apply_stimulus(3'd7, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        step();
        req_valid = 1'b0;
        check_output("op7_err", 32'(err), 32'h1);
        check_output("op7_valid", 32'(out_valid), 32'h0);
        check_output("op7_addr", 32'(out_addr), 32'h0058);

        $display("[TB] J with backpressure");
        out_ready = 1'b0;
        apply_stimulus(ENC_J, OP_J, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0100);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("j_hold_word%0d", i), out_word, 32'h0800_0100);
            check_output($sformatf("j_hold_valid%0d", i), 32'(out_valid), 32'h1);
            check_output($sformatf("j_hold_addr%0d", i), 32'(out_addr), 32'h0058);
            check_output($sformatf("j_hold_ready%0d", i), 32'(req_ready), 32'h0);
            if (i < 2) step();
        end
        out_ready = 1'b1;
        step();
        check_output("j_fired_valid", 32'(out_valid), 32'h0);
        check_output("j_fired_addr", 32'(out_addr), 32'h005C);
        check_output("j_fired_count", 32'(out_count), 32'h7);

        $display("[TB] reset during LI");
        out_ready = 1'b0;
        apply_stimulus(ENC_LI, 6'h00, 6'h00, 5'd0, 5'd4, 5'd0, 5'd0, 32'h1234_5678);
        step();
        req_valid = 1'b0;
        check_output("mid_li_lui", out_word, 32'h3C04_1234);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("mid_li_valid", 32'(out_valid), 32'h0);
        check_output("mid_li_addr", 32'(out_addr), 32'h0040);
        check_output("mid_li_count", 32'(out_count), 32'h0);
        out_ready = 1'b1;
        step();
        step();
        check_output("mid_li_no_ori", 32'(out_valid), 32'h0);
        check_output("mid_li_count2", 32'(out_count), 32'h0);

        $display("[TB] HALT");
        apply_stimulus(ENC_HALT, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        step();
        req_valid = 1'b0;
        check_output("halt_word", out_word, 32'hFFFF_FFFF);
        check_output("halt_ready", 32'(req_ready), 32'h0);
        check_output("halt_done_early", 32'(done), 32'h0);
        step();
        check_output("halt_done", 32'(done), 32'h1);
        check_output("halt_count", 32'(out_count), 32'h1);
        check_output("halt_addr", 32'(out_addr), 32'h0044);
        apply_stimulus(ENC_NOP, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        step();
        step();
        check_output("done_ready", 32'(req_ready), 32'h0);
        check_output("done_valid", 32'(out_valid), 32'h0);
        check_output("done_hold", 32'(done), 32'h1);
        check_output("done_count", 32'(out_count), 32'h1);
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("done_cleared", 32'(done), 32'h0);
        check_output("done_rst_ready", 32'(req_ready), 32'h1);

        $display("[TB] ADDR_W=4 wrap at full throughput");
        s_req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check_output($sformatf("wrap_valid%0d", k), 32'(s_out_valid), 32'h1);
            check_output($sformatf("wrap_addr%0d", k), 32'(s_out_addr), 32'((k * 4) % 16));
        end
        s_req_valid = 1'b0;
        step();
        check_output("wrap_count", 32'(s_out_count), 32'h5);
        check_output("wrap_addr_end", 32'(s_out_addr), 32'h4);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
